// File: rtl/ram_writer.sv
// rtl/ram_writer.sv - packs received bytes into RAM words and writes them frame by frame
//
// Purpose:
//   Collects bytes from a serial receiver and packs each group of four into one
//   RAM word, first byte in the most significant position. Each completed word
//   is written with a single-cycle write strobe. The write address then advances
//   and wraps at the end of the frame. The wrap raises a one-cycle frame_done pulse.
//
// Ports:
//   clk        in   system clock, all state updates on its rising edge
//   rst        in   synchronous active-high reset
//   rx_data    in   [7:0] received byte, valid while rx_ready is high
//   rx_ready   in   one-cycle byte strobe
//   restart    in   synchronous frame resynchronisation (address and byte count to 0)
//   adress     out  [ADRESS_BITS-1:0] RAM write address
//   data_out   out  [RAM_WIDTH-1:0] RAM write data, held between writes
//   write_en   out  RAM write strobe, high for exactly one cycle per word
//   frame_done out  one-cycle pulse after the last word of a frame is written
//
// Priority of the inputs is rst > restart > rx_ready. All outputs come directly
// from flops.

module ram_writer #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = (480 * 360 * 24) / RAM_WIDTH,
    localparam int ADRESS_BITS = $clog2(RAM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    input  logic                   restart,
    output logic [ADRESS_BITS-1:0] adress,
    output logic [RAM_WIDTH-1:0]   data_out,
    output logic                   write_en,
    output logic                   frame_done
);

    // Only 32-bit words are supported: three buffered bytes plus the incoming one.
    localparam logic [ADRESS_BITS-1:0] LAST_ADDR = ADRESS_BITS'(RAM_DEPTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        WRITE   = 1'b1
    } state_e;

    state_e                 state_q;
    logic [1:0]             cnt_q;
    logic [23:0]            pack_q;
    logic [ADRESS_BITS-1:0] adress_q;
    logic [RAM_WIDTH-1:0]   data_q;
    logic                   we_q;
    logic                   fd_q;

    logic                   at_last_d;
    logic [ADRESS_BITS-1:0] adress_next_d;
    logic [RAM_WIDTH-1:0]   word_d;

    always_comb begin
        at_last_d     = (adress_q == LAST_ADDR);
        adress_next_d = at_last_d ? '0 : adress_q + ADRESS_BITS'(1);
        // The fourth byte goes straight into the word, never through pack_q.
        word_d        = {pack_q, rx_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            cnt_q    <= 2'd0;
            pack_q   <= 24'd0;
            adress_q <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else if (restart) begin
            // A byte arriving with restart is dropped. data_out keeps its last value.
            state_q  <= COLLECT;
            cnt_q    <= 2'd0;
            adress_q <= '0;
            we_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            fd_q <= 1'b0;

            // WRITE always lasts one cycle. The address moves only after the
            // strobe, so adress/data_out stay stable while write_en is high.
            if (state_q == WRITE) begin
                state_q  <= COLLECT;
                we_q     <= 1'b0;
                adress_q <= adress_next_d;
                fd_q     <= at_last_d;
            end

            // A byte can arrive during WRITE. It is always the first byte of the
            // next word, since the fourth byte cannot come one cycle after the
            // previous fourth. So it lands in pack_q and leaves data_out alone.
            if (rx_ready) begin
                cnt_q <= cnt_q + 2'd1;
                case (cnt_q)
                    2'd0: pack_q[23:16] <= rx_data;
                    2'd1: pack_q[15:8]  <= rx_data;
                    2'd2: pack_q[7:0]   <= rx_data;
                    default: begin
                        data_q  <= word_d;
                        we_q    <= 1'b1;
                        state_q <= WRITE;
                    end
                endcase
            end
        end
    end

    assign adress     = adress_q;
    assign data_out   = data_q;
    assign write_en   = we_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ram_writer.sv
// tb/tb_ram_writer.sv - directed self-checking bench for ram_writer

module tb_ram_writer;

    localparam int DEPTH = 6;
    localparam int AB    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          restart;
    logic          rx_ready;
    logic [7:0]    rx_data;

    logic [AB-1:0] adress;
    logic [31:0]   data_out;
    logic          write_en;
    logic          frame_done;

    logic [16:0]   f_adress;
    logic [31:0]   f_data;
    logic          f_we;
    logic          f_fd;

    int checks   = 0;
    int failures = 0;
    int we_run   = 0;
    int we_max   = 0;
    int fd_cnt   = 0;

    always #5 clk = ~clk;

    ram_writer #(.RAM_WIDTH(32), .RAM_DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .adress     (adress),
        .data_out   (data_out),
        .write_en   (write_en),
        .frame_done (frame_done)
    );

    ram_writer u_full (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .adress     (f_adress),
        .data_out   (f_data),
        .write_en   (f_we),
        .frame_done (f_fd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w);
        put(w[31:24]);
        put(w[23:16]);
        put(w[15:8]);
        put(w[7:0]);
    endtask

    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            we_run <= we_run + 1;
            if (we_run + 1 > we_max) we_max <= we_run + 1;
        end else begin
            we_run <= 0;
        end
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; restart = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
        tick();
        tick();
        rx_data = 8'hEE; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0; rst = 1'b0;
        check("reset_adress", 32'(adress), 32'd0);
        check("reset_data", data_out, 32'd0);
        check("reset_we", 32'(write_en), 32'd0);
        check("reset_fd", 32'(frame_done), 32'd0);

        put(8'h11); tick(); tick();
        put(8'h22); tick(); tick();
        put(8'h33); tick(); tick();
        put(8'h44);
        check("w1_we", 32'(write_en), 32'd1);
        check("w1_data", data_out, 32'h11223344);
        check("w1_adress", 32'(adress), 32'd0);
        check("full_w1_data", f_data, 32'h11223344);
        check("full_w1_adress", 32'(f_adress), 32'd0);
        tick();
        check("w1_we_off", 32'(write_en), 32'd0);
        check("w1_adress_after", 32'(adress), 32'd1);
        check("w1_data_hold", data_out, 32'h11223344);
        check("full_adress_after", 32'(f_adress), 32'd1);

        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        check("b2b_a_we", 32'(write_en), 32'd1);
        check("b2b_a_data", data_out, 32'h01020304);
        check("b2b_a_adress", 32'(adress), 32'd1);
        put(8'h05);
        check("b2b_mid_we", 32'(write_en), 32'd0);
        check("b2b_mid_data", data_out, 32'h01020304);
        check("b2b_mid_adress", 32'(adress), 32'd2);
        put(8'h06); put(8'h07); put(8'h08);
        check("b2b_b_we", 32'(write_en), 32'd1);
        check("b2b_b_data", data_out, 32'h05060708);
        check("b2b_b_adress", 32'(adress), 32'd2);
        tick();
        check("b2b_adress_after", 32'(adress), 32'd3);

        put(8'h61); put(8'h62); put(8'h63);
        rx_data = 8'h64; rx_ready = 1'b1; restart = 1'b1;
        tick();
        rx_ready = 1'b0; restart = 1'b0;
        check("rs4_we", 32'(write_en), 32'd0);
        check("rs4_adress", 32'(adress), 32'd0);
        check("rs4_data_hold", data_out, 32'h05060708);
        tick();
        check("rs4_no_late_we", 32'(write_en), 32'd0);
        put_word(32'h10203040);
        check("rs4_next_we", 32'(write_en), 32'd1);
        check("rs4_next_data", data_out, 32'h10203040);
        check("rs4_next_adress", 32'(adress), 32'd0);
        tick();

        put(8'h71); put(8'h72);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rs2_adress", 32'(adress), 32'd0);
        put_word(32'hAABBCCDD);
        check("rs2_we", 32'(write_en), 32'd1);
        check("rs2_data", data_out, 32'hAABBCCDD);
        check("rs2_adress_w", 32'(adress), 32'd0);
        tick();
        check("rs2_fd", 32'(frame_done), 32'd0);
        check("rs2_fd_cnt", 32'(fd_cnt), 32'd0);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            put_word(32'h01000000 + 32'(i));
            check("fill_adress", 32'(adress), 32'(i));
            tick();
        end
        check("fill_end_adress", 32'(adress), 32'(DEPTH - 1));
        check("fill_fd_cnt", 32'(fd_cnt), 32'd0);
        put_word(32'hDEADBEEF);
        check("last_we", 32'(write_en), 32'd1);
        check("last_adress", 32'(adress), 32'(DEPTH - 1));
        check("last_data", data_out, 32'hDEADBEEF);
        tick();
        check("wrap_adress", 32'(adress), 32'd0);
        check("wrap_fd", 32'(frame_done), 32'd1);
        check("wrap_we", 32'(write_en), 32'd0);
        tick();
        check("wrap_fd_off", 32'(frame_done), 32'd0);
        check("wrap_fd_cnt", 32'(fd_cnt), 32'd1);

        for (int i = 0; i < DEPTH - 1; i++) begin
            put_word(32'h02000000 + 32'(i));
            tick();
        end
        put_word(32'hCAFEF00D);
        check("rsw_we", 32'(write_en), 32'd1);
        check("rsw_adress", 32'(adress), 32'(DEPTH - 1));
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rsw_we_off", 32'(write_en), 32'd0);
        check("rsw_adress_0", 32'(adress), 32'd0);
        check("rsw_fd", 32'(frame_done), 32'd0);
        tick();
        check("rsw_fd_late", 32'(frame_done), 32'd0);
        check("rsw_fd_cnt", 32'(fd_cnt), 32'd1);

        put_word(32'h0A0B0C0D);
        check("rstw_we", 32'(write_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_adress", 32'(adress), 32'd0);
        check("rstw_data", data_out, 32'd0);
        check("rstw_we_off", 32'(write_en), 32'd0);
        check("rstw_fd", 32'(frame_done), 32'd0);
        put(8'h21); put(8'h22); put(8'h23);
        rst = 1'b1; rx_data = 8'h24; rx_ready = 1'b1;
        tick();
        rst = 1'b0; rx_ready = 1'b0;
        check("rst3_data", data_out, 32'd0);
        check("rst3_we", 32'(write_en), 32'd0);
        put_word(32'h55667788);
        check("rst3_next_we", 32'(write_en), 32'd1);
        check("rst3_next_data", data_out, 32'h55667788);
        check("rst3_next_adress", 32'(adress), 32'd0);
        tick();
        check("rst3_adress_after", 32'(adress), 32'd1);
        tick();

        check("we_max_run", 32'(we_max), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_writer.md
RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 32, giving the RAM word width in bits; only 32 is supported.
REQ-002 The block SHALL have parameter RAM_DEPTH, default (480*360*24)/RAM_WIDTH = 129600, giving the number of RAM words in one frame.
REQ-003 The block SHALL have localparam ADRESS_BITS = $clog2(RAM_DEPTH), which is 17 at the defaults.
REQ-004 Port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port rx_data, input, 8 bits: received byte from the serial receiver.
REQ-007 Port rx_ready, input, 1 bit: one-cycle strobe; rx_data is valid in that cycle.
REQ-008 Port restart, input, 1 bit: synchronous frame resynchronisation request.
REQ-009 Port adress, output, ADRESS_BITS: RAM write address.
REQ-010 Port data_out, output, RAM_WIDTH: RAM write data.
REQ-011 Port write_en, output, 1 bit: RAM write strobe; adress and data_out are valid while it is high.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse after the last word of a frame is written.
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-014 The block SHALL pack 4 consecutive accepted bytes into one word, MSB first: byte0 to bits [31:24], byte1 to [23:16], byte2 to [15:8], byte3 to [7:0].
REQ-015 A 2-bit byte counter SHALL increment on each accepted byte and wrap from 3 to 0.
REQ-016 The counter SHALL count only bytes accepted while rst=0 and restart=0.
REQ-017 The FSM SHALL have exactly two states, COLLECT and WRITE, and SHALL be in COLLECT after reset.
REQ-018 In COLLECT, the 4th accepted byte at edge N SHALL load data_out with the packed word, set write_en=1 and enter WRITE at that same edge N.
REQ-019 In WRITE, the next edge SHALL set write_en=0 and return the FSM to COLLECT.
REQ-020 At the edge that leaves WRITE, adress SHALL increment by 1, or wrap to 0 if adress = RAM_DEPTH-1.
REQ-021 Write latency SHALL be 1 cycle: write_en is high exactly in cycle N+1 after the 4th rx_ready is sampled at edge N.
REQ-022 write_en SHALL never be high for more than 1 consecutive cycle.
REQ-023 data_out SHALL hold its value between writes.
REQ-024 rx_ready in WRITE SHALL be accepted into the packing register without loss.
REQ-025 A byte accepted in WRITE SHALL NOT alter data_out or adress during that write.
REQ-026 frame_done SHALL be 1 exactly in the cycle following a write to adress RAM_DEPTH-1, coincident with adress = 0, and 0 otherwise.
REQ-027 restart=1 SHALL, at the next edge, clear the byte counter and set adress to 0, write_en to 0 and the FSM to COLLECT.
REQ-028 restart=1 SHALL NOT produce a frame_done pulse.
REQ-029 A write already high in the restart cycle SHALL complete in that cycle.
REQ-030 When restart and rx_ready are high in the same cycle, restart SHALL win and the byte SHALL be discarded, including a byte that would have been the 4th.
REQ-031 Input priority SHALL be rst > restart > rx_ready.
REQ-032 rx_ready while rst=1 SHALL be ignored.
REQ-033 When rx_ready=0, no state SHALL change except the WRITE to COLLECT transition.

Reset
REQ-034 When rst=1 at an edge, the block SHALL set adress=0, data_out=0, write_en=0, frame_done=0, byte counter=0, packing register=0 and the FSM to COLLECT.
REQ-035 Reset mid-word or in WRITE SHALL discard any partial word, and the first byte after reset SHALL be treated as byte0.

Verification
REQ-036 Bytes 0x11, 0x22, 0x33, 0x44, one every 3 cycles -> one write_en pulse 1 cycle after 0x44, with data_out=0x11223344 and adress=0; afterwards adress=1.
REQ-037 Force adress to 129599 via 129599 full words and send one more word -> write at 129599, then adress=0 and frame_done=1 for exactly 1 cycle.
REQ-038 After 2 bytes, assert restart, then send 0xAA, 0xBB, 0xCC, 0xDD -> write of 0xAABBCCDD at adress 0, with no frame_done.
REQ-039 4th byte's rx_ready coincident with restart -> no write, counter=0, adress=0.
REQ-040 Bytes on 4 consecutive cycles with the next word's first byte in the WRITE cycle -> both words are correct and written at consecutive addresses.
REQ-041 rst asserted during WRITE and after 3 bytes, held 1 cycle -> all outputs are 0, and the next 4 bytes write at adress 0.
